pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 82 ++++++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg -- shared constants and next-PC source encoding for pc_sequencer.
//   PC_WIDTH_DEF / PC_STEP_DEF / PC_RESET_VECTOR_DEF / PC_RAS_DEPTH_DEF :
//     default parameter values for the sequencer.
//   pc_src_e : which source feeds the pc register on the next falling edge.
package pc_pkg;

   localparam int unsigned PC_WIDTH_DEF        = 32;
   localparam int unsigned PC_STEP_DEF         = 4;
   localparam int unsigned PC_RESET_VECTOR_DEF = 0;
   localparam int unsigned PC_RAS_DEPTH_DEF    = 8;

   typedef enum logic [2:0] {
      SRC_SEQ  = 3'd0,
      SRC_BR   = 3'd1,
      SRC_JMP  = 3'd2,
      SRC_CALL = 3'd3,
      SRC_RET  = 3'd4,
      SRC_HOLD = 3'd5
   } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack, state updates on falling clk edge.
//   clk, rst_n : clock, async active-low reset (pointer, count, err cleared;
//                entry contents are left as they are)
//   push       : write push_data on top (overwrites oldest entry when full)
//   pop        : remove top entry (ignored and flagged when empty)
//   push_data  : return address to store
//   top        : current top entry (meaningless while empty)
//   count      : number of valid entries, 0..DEPTH
//   full/empty : derived from registered count
//   err        : sticky overflow/underflow flag
// pop takes priority over push if both are requested in the same cycle.
module pc_ras #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   // ptr_q points at the next free slot; since DEPTH is a power of two the
   // pointer wraps for free, which makes a full-stack push land on the oldest
   // entry.
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign count   = cnt_q;
   assign err     = err_q;
   assign top     = mem_q[ptr_q - PW'(1)];
   assign do_push = push & ~pop;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (pop) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
         end
      end else if (push) begin
         ptr_d = ptr_q + PW'(1);
         if (full) err_d = 1'b1;
         else      cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Storage is not reset; only pointer/count define what is valid.
   always_ff @(negedge clk) begin
      if (do_push) mem_q[ptr_q] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with branch/jump/call/ret selection.
// State updates on the falling edge of clk; rst_n is async active-low.
//   stall               : hold pc and stack
//   br_taken/br_target  : conditional branch
//   jump/jmp_target     : unconditional jump
//   call                : jump to jmp_target, push pc+STEP
//   ret                 : pop return address and jump to it
//   pc / pc_seq         : registered pc / combinational pc+STEP
//   ras_empty/ras_full  : stack occupancy flags
//   ras_err             : sticky overflow/underflow
// Priority: stall > ret > call > jump > br_taken > sequential.
// Build option: define PC_SEQUENCER_RAS_EN to include the return-address
// stack. Without it call acts as jump, ret as a sequential step, and the
// stack flags are tied to empty/not-full/no-error.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = PC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF),
   parameter int unsigned      STEP         = PC_STEP_DEF,
   parameter int unsigned      RAS_DEPTH    = PC_RAS_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jump,
   input  logic             call,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("pc_sequencer: WIDTH must be 8..64");
   end
   if (RAS_DEPTH < 2 || RAS_DEPTH > 32 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_sequencer: RAS_DEPTH must be a power of 2 in 2..32");
   end

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ras_top;
   logic             ras_valid;   // a ret can actually pop
   pc_src_e          src;

   assign pc     = pc_q;
   assign pc_seq = pc_q + WIDTH'(STEP);   // wraps modulo 2^WIDTH

`ifdef PC_SEQUENCER_RAS_EN
   logic [$clog2(RAS_DEPTH):0] ras_count;
   logic                       ras_push, ras_pop;

   assign ras_push  = (src == SRC_CALL);
   // Any unstalled ret pops, so an empty-stack ret is flagged as underflow.
   assign ras_pop   = ret & ~stall;
   assign ras_valid = (ras_count != '0);

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_seq),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty),
      .err       (ras_err)
   );
`else
   assign ras_top   = '0;
   assign ras_valid = 1'b0;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_err   = 1'b0;
`endif

   // Priority decoder; a ret with nothing to pop degrades to a sequential step.
   always_comb begin
      src = SRC_SEQ;
      if      (stall)    src = SRC_HOLD;
      else if (ret)      src = ras_valid ? SRC_RET : SRC_SEQ;
      else if (call)     src = SRC_CALL;
      else if (jump)     src = SRC_JMP;
      else if (br_taken) src = SRC_BR;
   end

   always_comb begin
      pc_d = pc_seq;
      case (src)
         SRC_HOLD: pc_d = pc_q;
         SRC_RET:  pc_d = ras_top;
         SRC_CALL: pc_d = jmp_target;
         SRC_JMP:  pc_d = jmp_target;
         SRC_BR:   pc_d = br_target;
         default:  pc_d = pc_seq;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_VECTOR;
      else        pc_q <= pc_d;
   end

endmodule
